fu_cfg_seq: RTL

Configuration writer and sequencer for the PE functional-unit cluster. It accepts configuration words over a valid/ready stream and assembles them into CONFIG_ALL-bit contexts held in a small context store. On command it replays those contexts, one per cycle and for a set number of loops, onto the config_all bus read by the FU cluster. It sits between the array configuration network and the FU cluster. It is the producer of the cluster's config_all interface.

---
 rtl/fu_cfg_pkg.sv | 23 ++
 rtl/fu_cfg_ctx_mem.sv | 33 +++
 rtl/fu_cfg_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fu_cfg_pkg.sv
// Shared definitions for the FU-cluster configuration sequencer.
// Holds the context field widths, the default context and chunk geometry,
// and the sequencer state encoding.
package fu_cfg_pkg;

  // Field widths of one context, MSB to LSB: {cmac, cordic, logical, dmem}.
  localparam int CONFIG_CMAC   = 16;
  localparam int CONFIG_CORDIC = 8;
  localparam int CONFIG_LOGI   = 9;
  localparam int CONFIG_DMEM   = 31;

  localparam int DEF_CONFIG_ALL   = CONFIG_CMAC + CONFIG_CORDIC + CONFIG_LOGI + CONFIG_DMEM;
  localparam int DEF_CFG_IN_WIDTH = 16;

  // Number of input words that make one context at the default geometry.
  localparam int CHUNKS = DEF_CONFIG_ALL / DEF_CFG_IN_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fu_cfg_ctx_mem.sv
// Context store: NUM_CTX entries of WIDTH bits.
// One synchronous write port, one asynchronous (combinational) read port.
// The array is not reset; entries are only meaningful once written.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fu_cfg_ctx_mem #(
  parameter int NUM_CTX = 8,
  parameter int WIDTH   = 64,
  parameter int AW      = $clog2(NUM_CTX)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [NUM_CTX];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fu_cfg_seq.sv
// Configuration writer and sequencer for the PE functional-unit cluster.
// Assembles CFG_IN_WIDTH-bit words (least-significant chunk first) into
// CONFIG_ALL-bit contexts stored in a NUM_CTX-entry ring, then on a run
// command replays contexts 0..N-1 on config_all_o, one per cycle, for a
// given number of loops (0 = until abort).
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cfg_valid_i   : input word valid
//   cfg_ready_o   : input word ready (combinational)
//   cfg_data_i    : input configuration word
//   run_i         : start request, sampled only in IDLE
//   num_ctx_i     : contexts per loop (1..NUM_CTX)
//   iter_i        : loop count, 0 = endless
//   stall_i       : hold the replay while high
//   abort_i       : end the replay (beats stall_i)
//   clear_i       : forget all loaded contexts (IDLE only)
//   config_all_o  : registered context to the FU cluster
//   busy_o        : a context is being driven
//   done_o        : one-cycle pulse on normal completion
//   err_o         : one-cycle pulse on a rejected run request
//
// Handshake: a word transfers on a rising edge where cfg_valid_i and
// cfg_ready_o are both high. The producer keeps data stable while valid is
// high and not yet accepted; ready never depends on cfg_valid_i.
module fu_cfg_seq
  import fu_cfg_pkg::*;
#(
  parameter int CONFIG_ALL   = DEF_CONFIG_ALL,
  parameter int CFG_IN_WIDTH = DEF_CFG_IN_WIDTH,
  parameter int NUM_CTX      = 8,
  parameter int ITER_WIDTH   = 8,
  parameter logic [CONFIG_ALL-1:0] IDLE_CFG = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [CFG_IN_WIDTH-1:0]    cfg_data_i,
  input  logic                       run_i,
  input  logic [$clog2(NUM_CTX):0]   num_ctx_i,
  input  logic [ITER_WIDTH-1:0]      iter_i,
  input  logic                       stall_i,
  input  logic                       abort_i,
  input  logic                       clear_i,
  output logic [CONFIG_ALL-1:0]      config_all_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int NCHUNK = CONFIG_ALL / CFG_IN_WIDTH;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = $clog2(NUM_CTX);
  localparam int NW     = PW + 1;

  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [NW-1:0] CTX_MAX    = NW'(NUM_CTX);

  // State and datapath registers
  state_t                  state_q, state_n;
  logic [CW-1:0]           chunk_cnt_q;
  logic [PW-1:0]           wr_ptr_q;
  logic [NW-1:0]           loaded_cnt_q;
  logic [CONFIG_ALL-1:0]   asm_q, asm_nxt;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_n;
  logic [NW-1:0]           num_q, num_n;
  logic [ITER_WIDTH-1:0]   iter_q, iter_n;
  logic [CONFIG_ALL-1:0]   config_q, config_n;
  logic                    busy_q, busy_n;
  logic                    done_n, err_n;
  logic                    done_q, err_q;

  logic [PW-1:0]           raddr;
  logic [CONFIG_ALL-1:0]   rdata;

  logic accept_word, last_chunk, run_ok, start, reject;
  logic last_ctx, final_beat;

  assign cfg_ready_o = (state_q == IDLE) && !run_i && !clear_i;
  assign accept_word = cfg_valid_i && cfg_ready_o;
  assign last_chunk  = (chunk_cnt_q == LAST_CHUNK);

  // Assembly register with the incoming word dropped into its slot; on the
  // last chunk this is the complete context written to the store.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[CFG_IN_WIDTH*chunk_cnt_q +: CFG_IN_WIDTH] = cfg_data_i;
  end

  // A run needs a sensible context count that is actually loaded, and no
  // half-assembled context in flight.
  assign run_ok = (num_ctx_i != '0) && (num_ctx_i <= loaded_cnt_q) && (chunk_cnt_q == '0);
  assign start  = (state_q == IDLE) && run_i && run_ok;
  assign reject = (state_q == IDLE) && run_i && !run_ok;

  assign last_ctx   = ({1'b0, rd_ptr_q} == (num_q - NW'(1)));
  // iter_q == 0 means endless, so it never matches here.
  assign final_beat = last_ctx && (iter_q == ITER_WIDTH'(1));

  fu_cfg_ctx_mem #(
    .NUM_CTX (NUM_CTX),
    .WIDTH   (CONFIG_ALL),
    .AW      (PW)
  ) u_ctx_mem (
    .clk   (clk),
    .we    (accept_word && last_chunk),
    .waddr (wr_ptr_q),
    .wdata (asm_nxt),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Context loading and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      loaded_cnt_q <= '0;
      asm_q        <= '0;
    end else if ((state_q == IDLE) && clear_i) begin
      chunk_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      loaded_cnt_q <= '0;
    end else if (accept_word) begin
      asm_q <= asm_nxt;
      if (last_chunk) begin
        chunk_cnt_q <= '0;
        wr_ptr_q    <= wr_ptr_q + 1'b1;  // wraps: NUM_CTX is a power of two
        if (loaded_cnt_q != CTX_MAX) begin
          loaded_cnt_q <= loaded_cnt_q + 1'b1;
        end
      end else begin
        chunk_cnt_q <= chunk_cnt_q + 1'b1;
      end
    end
  end

  // FSM: state register (also registers the sequencer outputs)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      num_q    <= '0;
      iter_q   <= '0;
      config_q <= IDLE_CFG;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      rd_ptr_q <= rd_ptr_n;
      num_q    <= num_n;
      iter_q   <= iter_n;
      config_q <= config_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  // FSM: next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        if (abort_i) begin
          state_n = IDLE;
        end else if (!stall_i && final_beat) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs and replay datapath (next values of the registered outputs)
  always_comb begin
    config_n = config_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
    rd_ptr_n = rd_ptr_q;
    num_n    = num_q;
    iter_n   = iter_q;
    raddr    = '0;
    case (state_q)
      IDLE: begin
        config_n = IDLE_CFG;
        busy_n   = 1'b0;
        err_n    = reject;
        if (start) begin
          num_n    = num_ctx_i;
          iter_n   = iter_i;
          rd_ptr_n = '0;
          raddr    = '0;
          config_n = rdata;
          busy_n   = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          config_n = IDLE_CFG;
          busy_n   = 1'b0;
        end else if (stall_i) begin
          // hold everything
        end else if (last_ctx) begin
          if (final_beat) begin
            config_n = IDLE_CFG;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end else begin
            rd_ptr_n = '0;
            raddr    = '0;
            config_n = rdata;
            if (iter_q != '0) begin
              iter_n = iter_q - 1'b1;
            end
          end
        end else begin
          rd_ptr_n = rd_ptr_q + 1'b1;
          raddr    = rd_ptr_q + 1'b1;
          config_n = rdata;
        end
      end
      default: begin
        config_n = IDLE_CFG;
        busy_n   = 1'b0;
      end
    endcase
  end

  assign config_all_o = config_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
